// File: rtl/byte_pack_pkg.sv
// byte_pack_pkg: shared constants, debug state encoding and lane parity helper
// for the byte packer.
// Optional feature macro: BYTE_PACK_PARITY_EN (lane parity output).
package byte_pack_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int BYTES_DEF  = 4;
  localparam int CNT_W      = $clog2(BYTES_DEF) + 1;

  // Widest lane the parity helper accepts; callers zero-extend their lane.
  localparam int LANE_W_MAX = 64;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    HELD  = 2'd2
  } state_t;

  function automatic logic lane_parity(input logic [LANE_W_MAX-1:0] lane);
    return ^lane;
  endfunction

endpackage

// File: rtl/byte_pack_if.sv
// byte_pack_if: byte-in / packed-word-out handshake bundle.
//   in_valid, input_data, in_last, in_ready : byte side (valid/ready)
//   output_data, out_count, out_valid, out_ready : word side (valid/ready)
//   out_parity : per-lane parity, present only with BYTE_PACK_PARITY_EN
// master = upstream source / downstream sink, slave = the packer.
interface byte_pack_if
  import byte_pack_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int BYTES  = BYTES_DEF
);
  localparam int CW = $clog2(BYTES) + 1;

  logic                    in_valid;
  logic [DATA_W-1:0]       input_data;
  logic                    in_last;
  logic                    in_ready;
  logic [DATA_W*BYTES-1:0] output_data;
  logic [CW-1:0]           out_count;
  logic                    out_valid;
  logic                    out_ready;
`ifdef BYTE_PACK_PARITY_EN
  logic [BYTES-1:0]        out_parity;
`endif

  modport master (
    output in_valid, input_data, in_last, out_ready,
`ifdef BYTE_PACK_PARITY_EN
    input  out_parity,
`endif
    input  in_ready, output_data, out_count, out_valid
  );

  modport slave (
    input  in_valid, input_data, in_last, out_ready,
`ifdef BYTE_PACK_PARITY_EN
    output out_parity,
`endif
    output in_ready, output_data, out_count, out_valid
  );

endinterface

// File: rtl/byte_pack_outreg.sv
// byte_pack_outreg: one-word output register for the byte packer.
//   CLK, RST         : clock, synchronous active-high reset
//   load             : closing byte accepted; capture load_data/load_count
//   out_ready        : sink accepts the held word
//   out_data/out_count/out_valid : registered word
//   out_parity       : per-lane parity (BYTE_PACK_PARITY_EN only)
// The top never loads while a word is held and not draining, so load alone
// decides whether new data enters.
module byte_pack_outreg
  import byte_pack_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int BYTES  = BYTES_DEF,
  localparam int CW    = $clog2(BYTES) + 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    load,
  input  logic [DATA_W*BYTES-1:0] load_data,
  input  logic [CW-1:0]           load_count,
  input  logic                    out_ready,
`ifdef BYTE_PACK_PARITY_EN
  output logic [BYTES-1:0]        out_parity,
`endif
  output logic [DATA_W*BYTES-1:0] out_data,
  output logic [CW-1:0]           out_count,
  output logic                    out_valid
);

  logic [DATA_W*BYTES-1:0] data_q, data_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    count_d = count_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = load_data;
      count_d = load_count;
      valid_d = 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      data_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_count = count_q;
  assign out_valid = valid_q;

`ifdef BYTE_PACK_PARITY_EN
  logic [BYTES-1:0] parity_q, parity_d;

  always_comb begin
    parity_d = parity_q;
    if (load) begin
      for (int k = 0; k < BYTES; k++) begin
        parity_d[k] = lane_parity(LANE_W_MAX'(load_data[k*DATA_W +: DATA_W]));
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) parity_q <= '0;
    else     parity_q <= parity_d;
  end

  assign out_parity = parity_q;
`endif

endmodule

// File: rtl/byte_pack_4_8bits.sv
// byte_pack_4_8bits: packs a byte stream into BYTES-byte words, first byte in
// the LSB lane; in_last closes a word early and zero-pads the upper lanes.
//   CLK, RST : clock, synchronous active-high reset
//   bus      : byte_pack_if slave (byte in, packed word out)
// Optional feature macro: BYTE_PACK_PARITY_EN adds bus.out_parity.
// A closing byte lands in the output register on the edge it is accepted.
//
// state | meaning
// EMPTY | no partial word, output register empty
// FILL  | partial word collecting, output register empty
// HELD  | output word valid (a partial word may also be collecting)
module byte_pack_4_8bits
  import byte_pack_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int BYTES  = BYTES_DEF
) (
  input logic      CLK,
  input logic      RST,
  byte_pack_if.slave bus
);

  localparam int CW = $clog2(BYTES) + 1;

  logic [DATA_W*(BYTES-1)-1:0] col_data_q, col_data_d;
  logic [CW-1:0]               col_cnt_q, col_cnt_d;
  logic [DATA_W*BYTES-1:0]     load_word;
  logic                        closing_capable, in_xfer, closing;
  state_t                      state;

  always_comb begin
    state = EMPTY;
    if (bus.out_valid)           state = HELD;
    else if (col_cnt_q != '0)    state = FILL;
  end

  // in_last is sampled without in_valid so in_ready never depends on in_valid.
  assign closing_capable = (col_cnt_q == CW'(BYTES-1)) || bus.in_last;
  assign bus.in_ready    = !RST && !((state == HELD) && closing_capable && !bus.out_ready);
  assign in_xfer         = bus.in_valid && bus.in_ready;
  assign closing         = in_xfer && closing_capable;

  always_comb begin
    load_word = '0;
    for (int k = 0; k < BYTES-1; k++) begin
      if (CW'(k) < col_cnt_q) load_word[k*DATA_W +: DATA_W] = col_data_q[k*DATA_W +: DATA_W];
    end
    for (int k = 0; k < BYTES; k++) begin
      if (CW'(k) == col_cnt_q) load_word[k*DATA_W +: DATA_W] = bus.input_data;
    end
  end

  always_comb begin
    col_data_d = col_data_q;
    col_cnt_d  = col_cnt_q;
    if (closing) begin
      col_data_d = '0;
      col_cnt_d  = '0;
    end else if (in_xfer) begin
      for (int k = 0; k < BYTES-1; k++) begin
        if (CW'(k) == col_cnt_q) col_data_d[k*DATA_W +: DATA_W] = bus.input_data;
      end
      col_cnt_d = col_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      col_data_q <= '0;
      col_cnt_q  <= '0;
    end else begin
      col_data_q <= col_data_d;
      col_cnt_q  <= col_cnt_d;
    end
  end

  byte_pack_outreg #(
    .DATA_W (DATA_W),
    .BYTES  (BYTES)
  ) u_outreg (
    .CLK        (CLK),
    .RST        (RST),
    .load       (closing),
    .load_data  (load_word),
    .load_count (col_cnt_q + CW'(1)),
    .out_ready  (bus.out_ready),
`ifdef BYTE_PACK_PARITY_EN
    .out_parity (bus.out_parity),
`endif
    .out_data   (bus.output_data),
    .out_count  (bus.out_count),
    .out_valid  (bus.out_valid)
  );

endmodule

// File: tb/tb_byte_pack_4_8bits.sv
// Directed bench for byte_pack_4_8bits (DATA_W=8, BYTES=4).
// Optional feature macro: BYTE_PACK_PARITY_EN enables the parity checks.
module tb_byte_pack_4_8bits;

  logic CLK = 1'b0;
  logic RST;
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  byte_pack_if #(.DATA_W(8), .BYTES(4)) bus ();

  byte_pack_4_8bits #(.DATA_W(8), .BYTES(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one byte, take one clock edge, return 1 time unit after the edge.
  task automatic send(input logic [7:0] b, input logic last);
    bus.in_valid   = 1'b1;
    bus.input_data = b;
    bus.in_last    = last;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  logic [7:0]  rb;
  logic [31:0] exp_word;
  int          words;

  initial begin
    RST            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.input_data = 8'h00;
    bus.in_last    = 1'b0;
    bus.out_ready  = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_output_data", 64'(bus.output_data), 64'd0);
    check("rst_out_count", 64'(bus.out_count), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    RST = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Full word
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    check("full_not_yet_valid", 64'(bus.out_valid), 64'd0);
    send(8'h44, 1'b0);
    check("full_valid", 64'(bus.out_valid), 64'd1);
    check("full_data", 64'(bus.output_data), 64'h44332211);
    check("full_count", 64'(bus.out_count), 64'd4);
    idle();
    check("full_one_cycle", 64'(bus.out_valid), 64'd0);

    // Early termination
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b1);
    check("early_valid", 64'(bus.out_valid), 64'd1);
    check("early_data", 64'(bus.output_data), 64'h0000BBAA);
    check("early_count", 64'(bus.out_count), 64'd2);
    idle();
    check("early_drained", 64'(bus.out_valid), 64'd0);

    // in_last on the first byte
    send(8'h5A, 1'b1);
    check("first_last_data", 64'(bus.output_data), 64'h0000005A);
    check("first_last_count", 64'(bus.out_count), 64'd1);
    // in_last on the fourth byte is an ordinary full word
    send(8'hC1, 1'b0);
    send(8'hC2, 1'b0);
    send(8'hC3, 1'b0);
    send(8'hC4, 1'b1);
    check("last_full_data", 64'(bus.output_data), 64'hC4C3C2C1);
    check("last_full_count", 64'(bus.out_count), 64'd4);
    idle();

    // Backpressure
    bus.out_ready = 1'b0;
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h04, 1'b0);
    check("bp_held_valid", 64'(bus.out_valid), 64'd1);
    check("bp_held_data", 64'(bus.output_data), 64'h04030201);
    bus.in_valid = 1'b1; bus.input_data = 8'h05; #1;
    check("bp_accept_05", 64'(bus.in_ready), 64'd1);
    send(8'h05, 1'b0);
    check("bp_accept_06", 64'(bus.in_ready), 64'd1);
    send(8'h06, 1'b0);
    check("bp_accept_07", 64'(bus.in_ready), 64'd1);
    send(8'h07, 1'b0);
    bus.input_data = 8'h08; #1;
    check("bp_stall_08", 64'(bus.in_ready), 64'd0);
    @(posedge CLK); #1;
    check("bp_still_held", 64'(bus.output_data), 64'h04030201);
    check("bp_still_stall", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1; #1;
    check("bp_release_ready", 64'(bus.in_ready), 64'd1);
    @(posedge CLK); #1;
    check("bp_b2b_valid", 64'(bus.out_valid), 64'd1);
    check("bp_b2b_data", 64'(bus.output_data), 64'h08070605);
    check("bp_b2b_count", 64'(bus.out_count), 64'd4);
    idle();
    check("bp_drained", 64'(bus.out_valid), 64'd0);

    // Streaming: 64 random bytes with the sink always ready
    words    = 0;
    exp_word = 32'h0;
    for (int i = 0; i < 64; i++) begin
      rb = 8'($urandom_range(0, 255));
      exp_word[(i % 4)*8 +: 8] = rb;
      bus.in_valid   = 1'b1;
      bus.input_data = rb;
      bus.in_last    = 1'b0;
      #1;
      check("stream_in_ready", 64'(bus.in_ready), 64'd1);
      @(posedge CLK); #1;
      check("stream_valid", 64'(bus.out_valid), 64'((i % 4) == 3));
      if ((i % 4) == 3) begin
        words++;
        check("stream_word", 64'(bus.output_data), 64'(exp_word));
      end
    end
    check("stream_word_count", 64'(words), 64'd16);
    idle();

    // Mid-word reset
    send(8'h10, 1'b0);
    send(8'h20, 1'b0);
    bus.in_valid = 1'b0;
    RST = 1'b1;
    #1;
    check("midrst_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge CLK); #1;
    check("midrst_valid", 64'(bus.out_valid), 64'd0);
    RST = 1'b0;
    send(8'h30, 1'b0);
    send(8'h40, 1'b0);
    send(8'h50, 1'b0);
    check("midrst_not_early", 64'(bus.out_valid), 64'd0);
    send(8'h60, 1'b0);
    check("midrst_data", 64'(bus.output_data), 64'h60504030);
    check("midrst_count", 64'(bus.out_count), 64'd4);
    idle();

`ifdef BYTE_PACK_PARITY_EN
    send(8'h01, 1'b0);
    send(8'h03, 1'b0);
    send(8'h07, 1'b0);
    send(8'hFF, 1'b0);
    check("par_full", 64'(bus.out_parity), 64'b0101);
    idle();
    check("par_held", 64'(bus.out_parity), 64'b0101);
    send(8'h01, 1'b0);
    send(8'h03, 1'b0);
    send(8'h07, 1'b1);
    check("par_early", 64'(bus.out_parity), 64'b0101);
    check("par_early_lane3", 64'(bus.output_data[31:24]), 64'd0);
    idle();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/byte_pack_4_8bits.md
Name: byte_pack_4_8bits

Overview:
- Consumer stage placed directly downstream of the 4-stage 8-bit DFF delay line.
- Collects the delayed byte stream into BYTES-byte words and presents them on a valid/ready output with a one-word output register.
- Supports an early word termination (in_last) that zero-pads the remaining byte lanes.
- Full throughput: one byte per cycle, no bubbles while the sink is ready.

Parameters:
- DATA_W, 8: byte width; matches the upstream delay line.
- BYTES, 4: bytes per packed word; legal range is 2 to 8.

Ports:
- CLK  in  1  single clock; all logic on posedge.
- RST  in  1  reset; synchronous, active-high.
- in_valid  in  1  input_data holds a byte this cycle.
- input_data  in  DATA_W  byte from the upstream delay stage.
- in_last  in  1  qualified by in_valid; this byte closes the current word.
- in_ready  out  1  the block accepts a byte this cycle.
- output_data  out  DATA_W*BYTES  packed word; first byte in the LSB lane.
- out_count  out  clog2(BYTES)+1  valid byte lanes in output_data (1..BYTES).
- out_valid  out  1  output_data/out_count are valid.
- out_ready  in  1  sink accepts the word this cycle.

Behaviour:
- Transfer rules: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
- Collector state: register col_data (DATA_W*(BYTES-1)) plus lane counter col_cnt (0..BYTES-1).
- Output register: out_valid, output_data, out_count.
- A word "closes" when an input transfer occurs with col_cnt==BYTES-1 or in_last=1.
- in_ready = !RST & !(closing-capable & out_valid & !out_ready).
  - Closing-capable means col_cnt==BYTES-1, or in_last is asserted.
  - Non-closing bytes are always accepted, even while the output register is held.
  - in_ready is combinational; it must not combinationally depend on in_valid.
- Non-closing transfer: byte written to lane col_cnt; col_cnt increments.
- Closing transfer, same edge:
  - output_data = {zeros, input_data, col_data lanes 0..col_cnt-1}; lanes above col_cnt are 0.
  - out_count = col_cnt+1.
  - out_valid = 1.
  - col_cnt = 0; col_data cleared.
- Latency: closing byte accepted at edge N, so out_valid=1 is visible after edge N (0 extra cycles).
- Output hold: out_valid stays 1 and output_data/out_count stay stable until an output transfer.
  - Output transfer with no closing input transfer on the same edge: out_valid goes to 0.
  - Output transfer and closing input transfer on the same edge: new word loaded, out_valid stays 1 (back-to-back).
- FSM (implicit in col_cnt/out_valid):
  - EMPTY (col_cnt=0, !out_valid)
  - FILL (col_cnt>0, !out_valid)
  - HELD (out_valid, col_cnt any)
  - STALL: HELD with a closing-capable byte present and out_ready=0; in_ready=0.
- Boundary cases:
  - in_last on the first byte gives out_count=1 with lanes 1..BYTES-1 = 0.
  - in_last with col_cnt==BYTES-1 is an ordinary full word, out_count=BYTES.
  - in_valid=0 makes in_last a don't-care.
- Reset: while RST=1 at an edge, out_valid=0, output_data=0, out_count=0, col_cnt=0, col_data=0; in_ready=0 while RST is high.
- Reset mid-word discards the partial word and any held word with no flush.
- First accepted byte is on the first edge with RST=0.

Optional Feature:
- Macro BYTE_PACK_PARITY_EN.
- Defined:
  - Extra port out_parity (out, BYTES): bit k = even parity (XOR reduce) of lane k.
  - Registered alongside output_data and held identically.
  - Zero-padded lanes give parity 0; reset value 0.
- Undefined: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package byte_pack_pkg:
  - localparam CNT_W = clog2(BYTES)+1.
  - Default DATA_W/BYTES constants.
  - Enum state_t {EMPTY, FILL, HELD} for debug/assertions.
  - Function lane_parity.
- Sub-module byte_pack_outreg: holds output_data/out_count/out_valid (and out_parity under BYTE_PACK_PARITY_EN) with the load/hold/drain rules.
- The top level contains the collector and in_ready logic.

Test Plan:
- Full words: RST high 2 cycles, then bytes 0x11,0x22,0x33,0x44 consecutive with out_ready=1. Expect output_data=0x44332211, out_count=4, out_valid for exactly 1 cycle after the 4th byte edge.
- Early termination: bytes 0xAA, 0xBB with in_last on 0xBB. Expect output_data=0x0000BBAA, out_count=2; the next word starts at lane 0.
- Backpressure: out_ready=0 while 8 bytes 0x01..0x08 arrive.
  - Expect word 0x04030201 held.
  - Bytes 0x05..0x07 accepted; in_ready=0 while 0x08 is presented.
  - Raise out_ready: 0x04030201 drains and 0x08070605 loads on the same edge.
- Streaming: 64 random bytes, in_valid and out_ready =1 throughout. Expect 16 words, no in_ready drop, and words matching a reference model.
- Mid-word reset: bytes 0x10,0x20 then RST for 1 cycle, then 0x30,0x40,0x50,0x60. Expect only 0x60504030 and no stale lanes.
- Parity (BYTE_PACK_PARITY_EN defined): bytes 0x01,0x03,0x07,0xFF. Expect out_parity=4'b0101; with in_last on 0x07, expect out_parity=4'b0101 and lane 3 = 0.
